// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM request, 2-entry output queue, branch redirect
// Hides the one-cycle ROM latency and keeps every in-flight word when decode stalls.

module fetch_unit #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  input  logic [INSTR_WIDTH-1:0] rom_q,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight;
  logic [1:0]             count;
  logic [INSTR_WIDTH-1:0] q_instr0, q_instr1;
  logic [ADDR_WIDTH-1:0]  q_pc0, q_pc1;
  logic                   pop;
  logic                   issue;
  logic [2:0]             occupancy;

  assign out_valid   = (count != 2'd0) & ~branch_valid;
  assign out_instr   = q_instr0;
  assign out_pc      = q_pc0;
  assign pop         = out_valid & out_ready;
  // Slots that will be taken after this edge, counting the word already in flight.
  assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = fetch_en & (occupancy < 3'd2);
  assign rom_address = branch_valid ? branch_target : fetch_pc;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      count       <= 2'd0;
      q_instr0    <= '0;
      q_instr1    <= '0;
      q_pc0       <= '0;
      q_pc1       <= '0;
    end else if (branch_valid) begin
      // Redirect drops the queue and the wrong-path word on rom_q.
      count       <= 2'd0;
      inflight    <= fetch_en;
      inflight_pc <= branch_target;
      fetch_pc    <= fetch_en ? branch_target + ADDR_WIDTH'(1) : branch_target;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
      end
      case ({inflight, pop})
        2'b01: begin
          q_instr0 <= q_instr1;
          q_pc0    <= q_pc1;
          count    <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            q_instr0 <= rom_q;
            q_pc0    <= inflight_pc;
          end else begin
            q_instr1 <= rom_q;
            q_pc1    <= inflight_pc;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q_instr0 <= rom_q;
            q_pc0    <= inflight_pc;
          end else begin
            q_instr0 <= q_instr1;
            q_pc0    <= q_pc1;
            q_instr1 <= rom_q;
            q_pc1    <= inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
// ROM contents: word i holds i + 0x100.

module tb_fetch_unit;

  localparam int IW = 32;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] rom_address;
  logic [IW-1:0] rom_q;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] wrap_seq[4];

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return IW'(a) + 32'h100;
  endfunction

  always @(posedge clock) rom_q <= rom_word(rom_address);

  fetch_unit #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(10'h000)) dut (
    .clock(clock),
    .rst(rst),
    .fetch_en(fetch_en),
    .rom_address(rom_address),
    .rom_q(rom_q),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_range(input logic [AW-1:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + AW'(i));
  endtask

  // Settle after the inputs were driven, score any handshake, advance to the next negedge.
  task automatic cyc();
    logic [AW-1:0] e;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {22'h0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", {22'h0, out_pc}, {22'h0, e});
        chk("deliver_instr", out_instr, rom_word(e));
      end
    end
    @(negedge clock);
  endtask

  initial begin
    wrap_seq[0] = 10'h3FE;
    wrap_seq[1] = 10'h3FF;
    wrap_seq[2] = 10'h000;
    wrap_seq[3] = 10'h001;
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    branch_valid = 1'b0; branch_target = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_instr", out_instr, 0);
    chk("reset_pc", out_pc, 0);
    chk("reset_rom_addr", rom_address, 0);
    @(negedge clock);

    // Stream from reset
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    push_range(10'h000, 64);
    #1 chk("startup_c0_valid", out_valid, 0);
    cyc();
    #1 chk("startup_c1_valid", out_valid, 0);
    cyc();
    #1 chk("first_valid", out_valid, 1);
    chk("first_pc", out_pc, 0);
    chk("first_instr", out_instr, 32'h100);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1 chk("stream_valid", out_valid, 1);
      cyc();
    end

    // Back-pressure with pc 4 at the head
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 4);
      chk("hold_instr", out_instr, 32'h104);
      if (i > 0) chk("hold_rom_addr", rom_address, 6);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("release_no_bubble", out_valid, 1);
      cyc();
    end

    // Redirect mid-stream
    branch_valid = 1'b1; branch_target = 10'h3F0;
    exp_q.delete();
    push_range(10'h3F0, 8);
    #1 chk("br_t0_valid", out_valid, 0);
    chk("br_rom_addr", rom_address, 10'h3F0);
    cyc();
    branch_valid = 1'b0;
    #1 chk("br_t1_valid", out_valid, 0);
    cyc();
    #1 chk("br_t2_valid", out_valid, 1);
    chk("br_t2_pc", out_pc, 10'h3F0);
    cyc();
    #1 chk("br_t3_pc", out_pc, 10'h3F1);
    cyc();

    // Redirect near the top of the address space to exercise wrap
    branch_valid = 1'b1; branch_target = 10'h3FE;
    exp_q.delete();
    push_range(10'h3FE, 40);
    cyc();
    branch_valid = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1 chk("wrap_valid", out_valid, 1);
      chk("wrap_pc", out_pc, wrap_seq[k]);
      cyc();
    end

    // fetch_en low with one queued and one in flight
    fetch_en = 1'b0;
    #1 chk("fe0_head_pc", out_pc, 2);
    cyc();
    #1 chk("fe0_second_valid", out_valid, 1);
    chk("fe0_second_pc", out_pc, 3);
    chk("fe0_rom_addr", rom_address, 4);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1 chk("fe0_idle_valid", out_valid, 0);
      chk("fe0_rom_held", rom_address, 4);
      cyc();
    end
    fetch_en = 1'b1;
    #1 chk("resume_rom_addr", rom_address, 4);
    cyc();
    cyc();
    #1 chk("resume_valid", out_valid, 1);
    chk("resume_pc", out_pc, 4);
    cyc();

    // Fill the queue, then reset asynchronously
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1 chk("rst_async_valid", out_valid, 0);
    chk("rst_async_pc", out_pc, 0);
    chk("rst_async_instr", out_instr, 0);
    chk("rst_async_rom_addr", rom_address, 0);
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    push_range(10'h000, 16);
    #1 chk("rerel_c0_valid", out_valid, 0);
    cyc();
    #1 chk("rerel_c1_valid", out_valid, 0);
    cyc();
    #1 chk("rerel_valid", out_valid, 1);
    chk("rerel_pc", out_pc, 0);
    chk("rerel_instr", out_instr, 32'h100);
    for (int i = 0; i < 4; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
